// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, the flag bundle and a flag builder.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef struct packed {
    logic ofl;
    logic zf;
    logic gzf;
    logic lzf;
    logic nezf;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_RESET = '{ofl: 1'b0, zf: 1'b1, gzf: 1'b0, lzf: 1'b0, nezf: 1'b0};

  function automatic alu_flags_t mk_flags(input logic ofl, input logic zero, input logic msb);
    alu_flags_t f;
    f.ofl  = ofl;
    f.zf   = zero;
    f.nezf = !zero;
    f.lzf  = msb;
    f.gzf  = !msb && !zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Combinational shifter/rotator for ROL, SLL, ROR, SRA (on a') and SRL (on the raw operands).
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_a_raw,
  input  logic [SHW-1:0]   i_sh,
  input  logic [SHW-1:0]   i_sh_raw,
  output logic [WIDTH-1:0] o_y
);

  logic [2*WIDTH-1:0] w_rol;
  logic [2*WIDTH-1:0] w_ror;

  // Rotates via a doubled operand: the upper/lower half of the shifted pair is the rotated word.
  always_comb begin
    w_rol = {i_a, i_a} << i_sh;
    w_ror = {i_a, i_a} >> i_sh;
    case (i_op)
      OP_ROL:  o_y = w_rol[2*WIDTH-1:WIDTH];
      OP_SLL:  o_y = i_a << i_sh;
      OP_ROR:  o_y = w_ror[WIDTH-1:0];
      OP_SRA:  o_y = $signed(i_a) >>> i_sh;
      OP_SRL:  o_y = i_a_raw >> i_sh_raw;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipelined.sv
// Two-stage valid/ready ALU. Optional sticky overflow flag with ofl_clr/ofl_sticky
// ports when ALU_PIPELINED_STICKY_OFL_EN is defined.
module alu_pipelined
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic             inv_a,
  input  logic             inv_b,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ofl,
  output logic             zf,
  output logic             gzf,
  output logic             lzf,
  output logic             nezf
`ifdef ALU_PIPELINED_STICKY_OFL_EN
  ,
  input  logic             ofl_clr,
  output logic             ofl_sticky
`endif
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_s1_cin;
  logic             r_s1_sign;
  logic             r_s1_inv_a;
  logic             r_s1_inv_b;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  alu_flags_t       r_s2_flags;

  logic             w_s2_load;
  logic             w_s1_load;
  logic [WIDTH-1:0] w_a_raw;
  logic [WIDTH-1:0] w_b_raw;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_result;
  logic             w_ofl;
  alu_flags_t       w_flags;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= OP_ADD;
      r_s1_cin   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_inv_a <= 1'b0;
      r_s1_inv_b <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a     <= inv_a ? ~a : a;
        r_s1_b     <= inv_b ? ~b : b;
        r_s1_op    <= op;
        r_s1_cin   <= cin;
        r_s1_sign  <= sign;
        r_s1_inv_a <= inv_a;
        r_s1_inv_b <= inv_b;
      end
    end
  end

  // SRL works on the untransformed operands, so undo the stored inversions.
  assign w_a_raw = r_s1_inv_a ? ~r_s1_a : r_s1_a;
  assign w_b_raw = r_s1_inv_b ? ~r_s1_b : r_s1_b;
  assign w_sum   = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, r_s1_cin};

  alu_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_a_raw  (w_a_raw),
    .i_sh     (r_s1_b[SHW-1:0]),
    .i_sh_raw (w_b_raw[SHW-1:0]),
    .o_y      (w_shift)
  );

  always_comb begin
    w_ofl = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_ofl    = r_s1_sign
                 ? (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1])
                 : w_sum[WIDTH];
      end
      OP_XOR:  w_result = r_s1_a ^ r_s1_b;
      OP_AND:  w_result = r_s1_a & r_s1_b;
      default: w_result = w_shift;
    endcase
    w_flags = mk_flags(w_ofl, w_result == '0, w_result[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= FLAGS_RESET;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_result;
        r_s2_flags  <= w_flags;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_s2_result;
  assign ofl       = r_s2_flags.ofl;
  assign zf        = r_s2_flags.zf;
  assign gzf       = r_s2_flags.gzf;
  assign lzf       = r_s2_flags.lzf;
  assign nezf      = r_s2_flags.nezf;

`ifdef ALU_PIPELINED_STICKY_OFL_EN
  logic r_ofl_sticky;

  // Setting on an overflowing output transfer takes priority over ofl_clr.
  always_ff @(posedge clk) begin
    if (rst)                                 r_ofl_sticky <= 1'b0;
    else if (out_valid && out_ready && ofl)  r_ofl_sticky <= 1'b1;
    else if (ofl_clr)                        r_ofl_sticky <= 1'b0;
  end

  assign ofl_sticky = r_ofl_sticky;
`endif

endmodule

// File: tb/tb_alu_pipelined.sv
// Directed self-checking bench for alu_pipelined: a WIDTH=16 and a WIDTH=32 instance.
module tb_alu_pipelined;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic        cin, inv_a, inv_b, sign;
  logic        out_ready;

  logic        in_valid16, in_ready16, out_valid16;
  logic [15:0] a16, b16, result16;
  logic        ofl16, zf16, gzf16, lzf16, nezf16;

  logic        in_valid32, in_ready32, out_valid32;
  logic [31:0] a32, b32, result32;
  logic        ofl32, zf32, gzf32, lzf32, nezf32;

`ifdef ALU_PIPELINED_STICKY_OFL_EN
  logic ofl_clr16, ofl_sticky16, ofl_clr32, ofl_sticky32;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipelined #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op), .cin(cin), .inv_a(inv_a), .inv_b(inv_b), .sign(sign),
    .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
    .ofl(ofl16), .zf(zf16), .gzf(gzf16), .lzf(lzf16), .nezf(nezf16)
`ifdef ALU_PIPELINED_STICKY_OFL_EN
    , .ofl_clr(ofl_clr16), .ofl_sticky(ofl_sticky16)
`endif
  );

  alu_pipelined #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .op(op), .cin(cin), .inv_a(inv_a), .inv_b(inv_b), .sign(sign),
    .out_valid(out_valid32), .out_ready(out_ready), .result(result32),
    .ofl(ofl32), .zf(zf32), .gzf(gzf32), .lzf(lzf32), .nezf(nezf32)
`ifdef ALU_PIPELINED_STICKY_OFL_EN
    , .ofl_clr(ofl_clr32), .ofl_sticky(ofl_sticky32)
`endif
  );

  // Flag vectors are packed {ofl, zf, gzf, lzf, nezf}.
  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        cin, ia, ib, s;
    logic [15:0] r;
    logic [4:0]  f;
  } vec16_t;

  task automatic beat16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic ia, input logic ib, input logic s,
                        output logic [15:0] r, output logic [4:0] f, output int lat);
    @(negedge clk);
    op = o; a16 = x; b16 = y; cin = c; inv_a = ia; inv_b = ib; sign = s; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    lat = -1; r = '0; f = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid16) begin
        lat = k; r = result16; f = {ofl16, zf16, gzf16, lzf16, nezf16};
        break;
      end
    end
  endtask

  task automatic beat32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [4:0] f, output int lat);
    @(negedge clk);
    op = o; a32 = x; b32 = y; cin = 1'b0; inv_a = 1'b0; inv_b = 1'b0; sign = 1'b0; in_valid32 = 1'b1;
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    lat = -1; r = '0; f = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid32) begin
        lat = k; r = result32; f = {ofl32, zf32, gzf32, lzf32, nezf32};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid16, result16, ofl16, zf16, gzf16, lzf16, nezf16} !== {1'b0, 16'h0, 5'b01000}) begin
      n_fail++;
      $display("FAIL reset16: got v=%b r=%h f=%b%b%b%b%b expected v=0 r=0000 f=01000",
               out_valid16, result16, ofl16, zf16, gzf16, lzf16, nezf16);
    end
    n_checks++;
    if ({out_valid32, result32, ofl32, zf32, gzf32, lzf32, nezf32} !== {1'b0, 32'h0, 5'b01000}) begin
      n_fail++;
      $display("FAIL reset32: got v=%b r=%h expected v=0 r=00000000 f=01000", out_valid32, result32);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready16 !== 1'b1 || in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready16, in_ready32);
    end
  endtask

  task automatic test_ops16();
    vec16_t v[$];
    logic [15:0] r;
    logic [4:0]  f;
    int          lat;
    v.push_back(vec16_t'{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 5'b10011});
    v.push_back(vec16_t'{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b11000});
    v.push_back(vec16_t'{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 5'b01000});
    v.push_back(vec16_t'{OP_ADD, 16'h0003, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0008, 5'b00101});
    v.push_back(vec16_t'{OP_ADD, 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 5'b10101});
    v.push_back(vec16_t'{OP_ADD, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 5'b01000});
    v.push_back(vec16_t'{OP_XOR, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0FF0, 5'b00101});
    v.push_back(vec16_t'{OP_AND, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF000, 5'b00011});
    v.push_back(vec16_t'{OP_AND, 16'h0F0F, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0, 16'hF000, 5'b00011});
    v.push_back(vec16_t'{OP_SLL, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 5'b00011});
    v.push_back(vec16_t'{OP_SLL, 16'h0003, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0006, 5'b00101});
    v.push_back(vec16_t'{OP_ROL, 16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 5'b00101});
    v.push_back(vec16_t'{OP_ROL, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 5'b00101});
    v.push_back(vec16_t'{OP_ROR, 16'h0001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 5'b00101});
    v.push_back(vec16_t'{OP_ROR, 16'hABCD, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'hABCD, 5'b00011});
    v.push_back(vec16_t'{OP_SRA, 16'h8000, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF800, 5'b00011});
    v.push_back(vec16_t'{OP_SRA, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001, 5'b00011});
    v.push_back(vec16_t'{OP_SRL, 16'h8000, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0800, 5'b00101});
    v.push_back(vec16_t'{OP_SRL, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3FFF, 5'b00101});
    v.push_back(vec16_t'{OP_SRL, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 5'b00101});
    v.push_back(vec16_t'{OP_SRL, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 5'b00011});
    out_ready = 1'b1;
    foreach (v[i]) begin
      beat16(v[i].op, v[i].a, v[i].b, v[i].cin, v[i].ia, v[i].ib, v[i].s, r, f, lat);
      n_checks++;
      if (lat !== 2 || r !== v[i].r || f !== v[i].f) begin
        n_fail++;
        $display("FAIL op16[%0d]: got lat=%0d r=%h f=%b expected lat=2 r=%h f=%b",
                 i, lat, r, f, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_ops32();
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    out_ready = 1'b1;
    beat32(OP_SRA, 32'h8000_0000, 32'h0000_001F, r, f, lat);
    n_checks++;
    if (lat !== 2 || r !== 32'hFFFF_FFFF || f !== 5'b00011) begin
      n_fail++;
      $display("FAIL sra32: got lat=%0d r=%h f=%b expected lat=2 r=ffffffff f=00011", lat, r, f);
    end
    beat32(OP_ROR, 32'h0000_0001, 32'h0000_0001, r, f, lat);
    n_checks++;
    if (lat !== 2 || r !== 32'h8000_0000 || f !== 5'b00011) begin
      n_fail++;
      $display("FAIL ror32: got lat=%0d r=%h f=%b expected lat=2 r=80000000 f=00011", lat, r, f);
    end
    beat32(OP_SRL, 32'h8000_0000, 32'h0000_001F, r, f, lat);
    n_checks++;
    if (lat !== 2 || r !== 32'h0000_0001 || f !== 5'b00101) begin
      n_fail++;
      $display("FAIL srl32: got lat=%0d r=%h f=%b expected lat=2 r=00000001 f=00101", lat, r, f);
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got  = 0;
    logic exp_rdy;
    op = OP_ADD; b16 = 16'h0100; cin = 1'b0; inv_a = 1'b0; inv_b = 1'b0; sign = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready  = !(cyc >= 3 && cyc <= 6);
      in_valid16 = (sent < 8);
      a16        = 16'(sent);
      #1;
      exp_rdy = !((sent - got) == 2 && !out_ready);
      n_checks++;
      if (in_ready16 !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_in_ready[cyc %0d]: got %b expected %b", cyc, in_ready16, exp_rdy);
      end
      if (out_valid16 && out_ready) begin
        n_checks++;
        if (result16 !== 16'h0100 + 16'(got)) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got %h expected %h", got, result16, 16'h0100 + 16'(got));
        end
        got++;
      end
      if (in_valid16 && in_ready16) sent++;
    end
    @(negedge clk);
    in_valid16 = 1'b0;
    out_ready  = 1'b1;
    n_checks++;
    if (got !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d beats expected 8", got);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid16 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_extra: got out_valid=%b expected 0", out_valid16);
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    op = OP_XOR; a16 = 16'h1111; b16 = 16'h0000; cin = 1'b0; inv_a = 1'b0; inv_b = 1'b0; sign = 1'b0;
    in_valid16 = 1'b1;
    @(negedge clk);
    a16 = 16'h2222;
    @(negedge clk);
    in_valid16 = 1'b0;
    n_checks++;
    if (out_valid16 !== 1'b1 || in_ready16 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_full: got out_valid=%b in_ready=%b expected 1/0", out_valid16, in_ready16);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid16, result16, ofl16, zf16, gzf16, lzf16, nezf16} !== {1'b0, 16'h0, 5'b01000}) begin
      n_fail++;
      $display("FAIL rstmid_state: got v=%b r=%h f=%b%b%b%b%b expected v=0 r=0000 f=01000",
               out_valid16, result16, ofl16, zf16, gzf16, lzf16, nezf16);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_in_ready: got %b expected 1", in_ready16);
    end
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (out_valid16 !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale: got out_valid=%b result=%h expected out_valid 0", out_valid16, result16);
      end
    end
  endtask

`ifdef ALU_PIPELINED_STICKY_OFL_EN
  task automatic test_sticky();
    logic [15:0] r;
    logic [4:0]  f;
    int          lat;
    out_ready = 1'b1;
    beat16(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, r, f, lat);
    @(negedge clk);
    n_checks++;
    if (ofl_sticky16 !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set: got %b expected 1", ofl_sticky16);
    end
    beat16(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, r, f, lat);
    ofl_clr16 = 1'b1;
    @(negedge clk);
    ofl_clr16 = 1'b0;
    n_checks++;
    if (ofl_sticky16 !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins: got %b expected 1", ofl_sticky16);
    end
    ofl_clr16 = 1'b1;
    @(negedge clk);
    ofl_clr16 = 1'b0;
    n_checks++;
    if (ofl_sticky16 !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear: got %b expected 0", ofl_sticky16);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; op = OP_ADD; cin = 1'b0; inv_a = 1'b0; inv_b = 1'b0; sign = 1'b0;
    out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0;
`ifdef ALU_PIPELINED_STICKY_OFL_EN
    ofl_clr16 = 1'b0; ofl_clr32 = 1'b0;
`endif
    test_reset();
    test_ops16();
    test_ops32();
    test_back_to_back();
    test_reset_midflight();
`ifdef ALU_PIPELINED_STICKY_OFL_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipelined.md
ALU_PIPELINED -- requirements
Module: alu_pipelined

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift/rotate count width; not overridden by instantiators.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  operand beat present.
REQ-006 Port in_ready  output  1  block accepts a beat this cycle.
REQ-007 Ports a, b  input  WIDTH each  operands.
REQ-008 Ports op  input  3; cin, inv_a, inv_b, sign  input  1 each  operation controls.
REQ-009 Port out_valid  output  1  result beat present.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port result  output  WIDTH  operation result.
REQ-012 Ports ofl, zf, gzf, lzf, nezf  output  1 each  result flags.

Function
REQ-013 Transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output); no other event moves data.
REQ-014 Two register stages: S1 holds a'=inv_a?~a:a, b'=inv_b?~b:b, op, cin, sign; S2 holds result and flags.
REQ-015 Latency exactly 2 cycles from input transfer to out_valid when out_ready stays high; throughput one beat per cycle.
REQ-016 S2 loads when !S2.valid||out_ready; S1 loads when !S1.valid||S2 loads; in_ready=!S1.valid||S2 loads (combinational, no bubble).
REQ-017 Stalled stage holds all fields unchanged; result/flags stable while out_valid&&!out_ready.
REQ-018 op 000 ADD: a'+b'+cin, WIDTH bits, carry-out internal.
REQ-019 op 001 SRL: original a (not a') logically shifted right by b[SHW-1:0], zero fill.
REQ-020 op 010 XOR: a'^b'; op 011 AND: a'&b'.
REQ-021 op 100 ROL, 101 SLL, 110 ROR, 111 SRA: a' by b'[SHW-1:0]; SRA fills with a'[WIDTH-1].
REQ-022 Count 0 returns operand unchanged for all shift/rotate ops.
REQ-023 ofl: ADD only; sign=1 -> a'[MSB]==b'[MSB] && sum[MSB]!=a'[MSB]; sign=0 -> carry-out; 0 for every other op.
REQ-024 zf=(result==0); nezf=!zf; lzf=result[MSB]; gzf=!result[MSB]&&!zf.
REQ-025 in_valid with in_ready low: beat not consumed; source holds it.

Reset
REQ-026 rst at clock edge clears S1.valid, S2.valid; out_valid=0, result=0, ofl=0, zf=1, nezf=0, gzf=0, lzf=0 next cycle.
REQ-027 rst mid-operation discards in-flight beats; no result emitted for them.
REQ-028 in_ready=1 in the cycle after rst deasserts.

Configuration
REQ-029 Macro ALU_PIPELINED_STICKY_OFL_EN defined: extra ports ofl_clr input 1 and ofl_sticky output 1; ofl_sticky sets on any output transfer with ofl=1, clears on rst or ofl_clr; set wins over clear in the same cycle.
REQ-030 Macro undefined: ports ofl_clr/ofl_sticky absent, no sticky register; all other behaviour identical.

Structure
REQ-031 Shared package alu_pkg holds op encodings as named localparams (OP_ADD..OP_SRA) and flag-bundle struct typedef.
REQ-032 One sub-module alu_shift_unit (WIDTH param) implements ROL/SLL/ROR/SRA/SRL combinationally; adder and logic inline.

Verification
REQ-033 WIDTH=16, ADD a=7FFF b=0001 cin=0 sign=1 -> result 8000, ofl=1, lzf=1, out_valid 2 cycles after accept.
REQ-034 WIDTH=16, ADD a=FFFF b=0001 sign=0 -> result 0000, ofl=1, zf=1, nezf=0; same with sign=1 -> ofl=0.
REQ-035 WIDTH=32, SRA a=80000000 b=1F -> FFFFFFFF; ROR a=00000001 b=1 -> 80000000; SRL a=80000000 b=1F -> 00000001.
REQ-036 Back-to-back 8 beats, out_ready low cycles 3-6 -> no loss/duplication, order preserved, in_ready low only while both stages full.
REQ-037 rst asserted with both stages valid -> out_valid=0 next cycle, flags at reset values, no stale beat after release.
REQ-038 Macro defined: ADD overflow beat then ofl_clr with concurrent overflow beat -> ofl_sticky stays 1; ofl_clr alone -> 0.
